// File: rtl/imm_gen_stage_if.sv
// rtl/imm_gen_stage_if.sv - handshake bundle between IF/ID, imm_gen_stage and ID/EX
// Purpose : groups the upstream instruction channel and the downstream decoded-entry
//           channel of imm_gen_stage into one parametrised bundle.
// Ports   : in_valid/in_ready/in_instr/in_pc    upstream instruction channel
//           out_valid/out_ready                  downstream handshake
//           out_imm/out_fmt/out_target/out_illegal/out_pc  decoded entry
// Modports: master = the side feeding instructions and consuming entries
//           slave  = imm_gen_stage itself
interface imm_gen_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal, out_pc
  );
endinterface

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered decode-stage immediate generator with 2-entry skid buffer
// Purpose : decodes the immediate, format tag, illegal flag and PC-relative target of each
//           accepted instruction and holds up to two decoded entries while EX stalls.
// Ports   : clk    clock, rising edge
//           rst_n  synchronous active-low reset
//           flush  drops every buffered entry
//           bus    imm_gen_stage_if slave modport (in_* upstream, out_* downstream)
// Formats : 0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm)
module imm_gen_stage #(
  parameter int XLEN      = 32,
  parameter bit EN_ZIMM   = 1'b1,
  parameter bit EN_TARGET = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  imm_gen_stage_if.slave  bus
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } state_t;

  // All base-ISA immediates fit in 32 bits; widen to XLEN by sign extension.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [31:0]     ins;
  logic [6:0]      opcode;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
  logic [XLEN-1:0] pc_sum;
  logic            pc_rel;
  entry_t          dec;

  assign ins    = bus.in_instr;
  assign opcode = ins[6:0];

  assign imm_i = sext32({{20{ins[31]}}, ins[31:20]});
  assign imm_s = sext32({{20{ins[31]}}, ins[31:25], ins[11:7]});
  assign imm_b = sext32({{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0});
  assign imm_u = sext32({ins[31:12], 12'b0});
  assign imm_j = sext32({{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0});
  assign imm_z = XLEN'(ins[19:15]);

  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc;
    pc_rel      = 1'b0;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111: begin
        dec.fmt = FMT_I;
        dec.imm = imm_i;
      end
      7'b1110011: begin
        // CSR immediate forms carry a 5-bit zimm in the rs1 field.
        if (EN_ZIMM && ins[14]) begin
          dec.fmt = FMT_Z;
          dec.imm = imm_z;
        end else begin
          dec.fmt = FMT_I;
          dec.imm = imm_i;
        end
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec.fmt = FMT_I;
          dec.imm = imm_i;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = imm_s;
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.imm = imm_b;
        pc_rel  = 1'b1;
      end
      7'b0110111: begin
        dec.fmt = FMT_U;
        dec.imm = imm_u;
      end
      7'b0010111: begin
        dec.fmt = FMT_U;
        dec.imm = imm_u;
        pc_rel  = 1'b1;
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        dec.imm = imm_j;
        pc_rel  = 1'b1;
      end
      7'b0110011, 7'b0001111: begin
        dec.fmt = FMT_NONE;
      end
      7'b0111011: begin
        if (XLEN != 64) begin
          dec.illegal = 1'b1;
        end
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase

    // JALR stays at pc: rs1 is not available in this stage.
    pc_sum = bus.in_pc + dec.imm;
    if (!EN_TARGET) begin
      dec.target = '0;
    end else if (pc_rel) begin
      dec.target = pc_sum;
    end else begin
      dec.target = bus.in_pc;
    end
  end

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  logic   out_valid_q;
  logic   in_ready_q;
  logic   accept;
  logic   pop;

  assign accept = bus.in_valid & in_ready_q;
  assign pop    = out_valid_q & bus.out_ready;

  // main_q always holds the oldest entry; skid_q is only live in ST_TWO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      state       <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_q      <= dec;
            state       <= ST_ONE;
            out_valid_q <= 1'b1;
          end
          in_ready_q <= 1'b1;
        end
        ST_ONE: begin
          if (accept && !pop) begin
            skid_q     <= dec;
            state      <= ST_TWO;
            in_ready_q <= 1'b0;
          end else if (accept && pop) begin
            main_q     <= dec;
            in_ready_q <= 1'b1;
          end else if (pop) begin
            state       <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_q     <= skid_q;
            state      <= ST_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_target  = main_q.target;
  assign bus.out_illegal = main_q.illegal;
  assign bus.out_pc      = main_q.pc;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - self-checking bench for imm_gen_stage at XLEN=32 and XLEN=64
module tb_imm_gen_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  imm_gen_stage_if #(.XLEN(32)) b32 ();
  imm_gen_stage_if #(.XLEN(64)) b64 ();

  assign b32.in_valid  = in_valid;
  assign b32.in_instr  = in_instr;
  assign b32.in_pc     = in_pc[31:0];
  assign b32.out_ready = out_ready;
  assign b64.in_valid  = in_valid;
  assign b64.in_instr  = in_instr;
  assign b64.in_pc     = in_pc;
  assign b64.out_ready = out_ready;

  imm_gen_stage #(.XLEN(32)) u32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));
  imm_gen_stage #(.XLEN(64)) u64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] tgt;
    logic [63:0] pc;
  } exp_t;

  typedef struct {
    bit          w64;
    logic [31:0] ins;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] tgt;
  } vec_t;

  exp_t q32[$];
  exp_t q64[$];
  vec_t tbl[$];

  logic [6:0] op_pool [0:15] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63, 7'h37,
                                 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h0F, 7'h00, 7'h7F, 7'h2B};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference decode: field values are rebuilt with signed arithmetic from the ISA layout.
  function automatic exp_t model(input int xlen, input logic [31:0] ins, input logic [63:0] pc);
    exp_t   e;
    longint x;
    longint imm;
    int     f;
    bit     ill;
    bit     rel;
    logic [63:0] mask;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    x    = longint'($signed(ins));
    f    = 0;
    ill  = 0;
    rel  = 0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: f = 1;
      7'h73:               f = ins[14] ? 6 : 1;
      7'h1B:               if (xlen == 64) f = 1; else ill = 1;
      7'h23:               f = 2;
      7'h63:               begin f = 3; rel = 1; end
      7'h37:               f = 4;
      7'h17:               begin f = 4; rel = 1; end
      7'h6F:               begin f = 5; rel = 1; end
      7'h33, 7'h0F:        f = 0;
      7'h3B:               if (xlen != 64) ill = 1;
      default:             ill = 1;
    endcase
    case (f)
      1: imm = x >>> 20;
      2: imm = (x >>> 25) * 32 + longint'(ins[11:7]);
      3: imm = (x >>> 31) * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
               + longint'(ins[11:8]) * 2;
      4: imm = (x >>> 12) * 4096;
      5: imm = (x >>> 31) * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
               + longint'(ins[30:21]) * 2;
      6: imm = longint'(ins[19:15]);
      default: imm = 0;
    endcase
    if (ill) begin
      imm = 0;
      f   = 0;
      rel = 0;
    end
    e.imm = 64'(imm) & mask;
    e.fmt = 3'(f);
    e.ill = ill;
    e.pc  = pc & mask;
    e.tgt = rel ? ((pc + 64'(imm)) & mask) : (pc & mask);
    return e;
  endfunction

  task automatic check_dut(input bit w);
    logic        ov, ir, ill;
    logic [63:0] imm, tgt, pc;
    logic [2:0]  fmt;
    int          qs;
    exp_t        e;
    string       p;
    p = w ? "x64" : "x32";
    if (w) begin
      ov = b64.out_valid; ir = b64.in_ready; imm = b64.out_imm; fmt = b64.out_fmt;
      tgt = b64.out_target; ill = b64.out_illegal; pc = b64.out_pc; qs = q64.size();
    end else begin
      ov = b32.out_valid; ir = b32.in_ready; imm = {32'b0, b32.out_imm}; fmt = b32.out_fmt;
      tgt = {32'b0, b32.out_target}; ill = b32.out_illegal; pc = {32'b0, b32.out_pc};
      qs = q32.size();
    end
    chk({p, " out_valid"}, {63'b0, ov}, {63'b0, qs > 0});
    chk({p, " in_ready"}, {63'b0, ir}, {63'b0, qs < 2});
    if (qs > 0) begin
      e = w ? q64[0] : q32[0];
      chk({p, " out_pc"}, pc, e.pc);
      chk({p, " out_imm"}, imm, e.imm);
      chk({p, " out_fmt"}, {61'b0, fmt}, {61'b0, e.fmt});
      chk({p, " out_illegal"}, {63'b0, ill}, {63'b0, e.ill});
      chk({p, " out_target"}, tgt, e.tgt);
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, advance the occupancy model.
  task automatic cycle(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                       input bit ordy, input bit fl, output bit acc);
    bit pop;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    check_dut(1'b0);
    check_dut(1'b1);
    acc = v && (q32.size() < 2) && !fl;
    pop = (q32.size() > 0) && ordy;
    if (fl) begin
      q32.delete();
      q64.delete();
    end else begin
      if (pop) begin
        q32.delete(0);
        q64.delete(0);
      end
      if (acc) begin
        q32.push_back(model(32, ins, pc));
        q64.push_back(model(64, ins, pc));
      end
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic apply_vec(input vec_t t, input int idx);
    string p;
    p = $sformatf("vec%0d", idx);
    in_valid  = 1'b1;
    in_instr  = t.ins;
    in_pc     = t.pc;
    out_ready = 1'b1;
    flush     = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    if (t.w64) begin
      chk({p, " out_valid"}, {63'b0, b64.out_valid}, 64'd1);
      chk({p, " out_imm"}, b64.out_imm, t.imm);
      chk({p, " out_fmt"}, {61'b0, b64.out_fmt}, {61'b0, t.fmt});
      chk({p, " out_illegal"}, {63'b0, b64.out_illegal}, {63'b0, t.ill});
      chk({p, " out_target"}, b64.out_target, t.tgt);
      chk({p, " out_pc"}, b64.out_pc, t.pc);
    end else begin
      chk({p, " out_valid"}, {63'b0, b32.out_valid}, 64'd1);
      chk({p, " out_imm"}, {32'b0, b32.out_imm}, t.imm);
      chk({p, " out_fmt"}, {61'b0, b32.out_fmt}, {61'b0, t.fmt});
      chk({p, " out_illegal"}, {63'b0, b32.out_illegal}, {63'b0, t.ill});
      chk({p, " out_target"}, {32'b0, b32.out_target}, t.tgt);
      chk({p, " out_pc"}, {32'b0, b32.out_pc}, t.pc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string p);
    chk({p, " x32 out_valid"}, {63'b0, b32.out_valid}, 64'd0);
    chk({p, " x32 in_ready"}, {63'b0, b32.in_ready}, 64'd1);
    chk({p, " x32 out_imm"}, {32'b0, b32.out_imm}, 64'd0);
    chk({p, " x32 out_fmt"}, {61'b0, b32.out_fmt}, 64'd0);
    chk({p, " x32 out_target"}, {32'b0, b32.out_target}, 64'd0);
    chk({p, " x32 out_illegal"}, {63'b0, b32.out_illegal}, 64'd0);
    chk({p, " x32 out_pc"}, {32'b0, b32.out_pc}, 64'd0);
    chk({p, " x64 out_valid"}, {63'b0, b64.out_valid}, 64'd0);
    chk({p, " x64 in_ready"}, {63'b0, b64.in_ready}, 64'd1);
    chk({p, " x64 out_imm"}, b64.out_imm, 64'd0);
    chk({p, " x64 out_target"}, b64.out_target, 64'd0);
    chk({p, " x64 out_pc"}, b64.out_pc, 64'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) == 0) return r;
    return {r[31:7], op_pool[$urandom_range(0, 15)]};
  endfunction

  initial begin
    bit          acc;
    int          idx;
    int          guard;
    logic [31:0] w3 [3];
    logic [63:0] p3 [3];

    tbl.push_back('{0, 32'hFFF00093, 64'h0,   64'hFFFFFFFF,          3'd1, 1'b0, 64'h0});
    tbl.push_back('{0, 32'hFE000EE3, 64'h100, 64'hFFFFFFFC,          3'd3, 1'b0, 64'hFC});
    tbl.push_back('{0, 32'hFE000EE3, 64'h0,   64'hFFFFFFFC,          3'd3, 1'b0, 64'hFFFFFFFC});
    tbl.push_back('{1, 32'h800000B7, 64'h40,  64'hFFFFFFFF80000000,  3'd4, 1'b0, 64'h40});
    tbl.push_back('{0, 32'h800000B7, 64'h40,  64'h80000000,          3'd4, 1'b0, 64'h40});
    tbl.push_back('{1, 32'h00001017, 64'hFFFFFFFFFFFFF000, 64'h1000, 3'd4, 1'b0, 64'h0});
    tbl.push_back('{0, 32'h00000000, 64'h200, 64'h0,                 3'd0, 1'b1, 64'h200});
    tbl.push_back('{0, 32'h0000001B, 64'h204, 64'h0,                 3'd0, 1'b1, 64'h204});
    tbl.push_back('{1, 32'hFFF0809B, 64'h300, 64'hFFFFFFFFFFFFFFFF,  3'd1, 1'b0, 64'h300});
    tbl.push_back('{0, 32'h300FD073, 64'h400, 64'h1F,                3'd6, 1'b0, 64'h400});
    tbl.push_back('{0, 32'h30009073, 64'h404, 64'h300,               3'd1, 1'b0, 64'h404});
    tbl.push_back('{0, 32'hFE20AC23, 64'h408, 64'hFFFFFFF8,          3'd2, 1'b0, 64'h408});
    tbl.push_back('{0, 32'h001000EF, 64'h1000, 64'h800,              3'd5, 1'b0, 64'h1800});
    tbl.push_back('{0, 32'h0000003B, 64'h500, 64'h0,                 3'd0, 1'b1, 64'h500});
    tbl.push_back('{1, 32'h0000003B, 64'h500, 64'h0,                 3'd0, 1'b0, 64'h500});
    tbl.push_back('{0, 32'h0FF0000F, 64'h504, 64'h0,                 3'd0, 1'b0, 64'h504});
    tbl.push_back('{0, 32'h00000010, 64'h508, 64'h0,                 3'd0, 1'b1, 64'h508});
    tbl.push_back('{0, 32'h004100E7, 64'h50C, 64'h4,                 3'd1, 1'b0, 64'h50C});

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 64'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], i);

    // Stalled downstream: third beat must wait, then everything drains in order.
    w3[0] = 32'h00100093; w3[1] = 32'hFE000EE3; w3[2] = 32'h001000EF;
    p3[0] = 64'h2000;     p3[1] = 64'h2004;     p3[2] = 64'h2008;
    idx = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, w3[idx], p3[idx], 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    guard = 0;
    while (idx < 3 && guard < 10) begin
      cycle(1'b1, w3[idx], p3[idx], 1'b1, 1'b0, acc);
      if (acc) idx++;
      guard++;
    end
    repeat (4) cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

    // Flush in the full state with a word on the input: nothing may emerge.
    cycle(1'b1, 32'h00200093, 64'h3000, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h00300093, 64'h3004, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h00400093, 64'h3008, 1'b0, 1'b1, acc);
    repeat (3) cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

    // One-cycle reset while holding an entry.
    cycle(1'b1, 32'hFFF00093, 64'h4000, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    q32.delete();
    q64.delete();
    @(posedge clk);
    #1;

    for (int k = 0; k < 800; k++) begin
      logic [31:0] ri;
      logic [63:0] rp;
      ri = rand_instr();
      rp = {$urandom, $urandom};
      cycle($urandom_range(0, 9) < 7, ri, rp, $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0, acc);
    end
    repeat (4) cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
